// File: rtl/toy_mdu.sv
// toy_mdu: iterative RV32M multiply/divide unit for the execute stage.
// One op in flight; single-cycle multiply, XLEN-step restoring divide.
package toy_pack;
   localparam int REG_WIDTH      = 32;
   localparam int INST_IDX_WIDTH = 5;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } funct3_mul_t;
endpackage

module toy_mdu
   import toy_pack::*;
#(
   parameter int XLEN = toy_pack::REG_WIDTH,
   parameter int RD_W = toy_pack::INST_IDX_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_vld,
   output logic            in_rdy,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [RD_W-1:0] in_rd,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [XLEN-1:0] out_result,
   output logic [RD_W-1:0] out_rd
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t          r_state;
   logic [2:0]      r_f3;
   logic [RD_W-1:0] r_rd;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_rem;
   logic [CW-1:0]   r_cnt;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_out_vld;
   logic [XLEN-1:0] r_out_res;
   logic [RD_W-1:0] r_out_rd;

   logic            w_sgn;
   logic            w_rem;
   logic            w_dz;
   logic            w_ovf;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic [XLEN-1:0] w_spec;

   always_comb begin
      w_sgn   = !in_funct3[0];
      w_rem   = in_funct3[1];
      w_dz    = (in_rs2 == '0);
      w_ovf   = w_sgn && (in_rs1 == MIN_NEG) && (in_rs2 == '1);
      w_abs_a = (w_sgn && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
      w_abs_b = (w_sgn && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;
      if (w_dz) w_spec = w_rem ? in_rs1 : '1;
      else      w_spec = w_rem ? '0 : MIN_NEG;
   end

   // Low 2*XLEN bits of the product are sign-agnostic once extended.
   logic              w_a_s;
   logic              w_b_s;
   logic [2*XLEN-1:0] w_ea;
   logic [2*XLEN-1:0] w_eb;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_mul_res;

   always_comb begin
      w_a_s     = (r_f3 != F3_MULHU) && r_a[XLEN-1];
      w_b_s     = ((r_f3 == F3_MUL) || (r_f3 == F3_MULH)) && r_b[XLEN-1];
      w_ea      = {{XLEN{w_a_s}}, r_a};
      w_eb      = {{XLEN{w_b_s}}, r_b};
      w_prod    = w_ea * w_eb;
      w_mul_res = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0]
                                   : w_prod[2*XLEN-1:XLEN];
   end

   logic [XLEN:0]   w_sh;
   logic [XLEN:0]   w_sub;
   logic            w_ge;
   logic [XLEN-1:0] w_q_nx;
   logic [XLEN-1:0] w_r_nx;
   logic [XLEN-1:0] w_div_res;

   always_comb begin
      w_sh   = {r_rem, r_a[XLEN-1]};
      w_sub  = w_sh - {1'b0, r_b};
      w_ge   = !w_sub[XLEN];
      w_q_nx = {r_a[XLEN-2:0], w_ge};
      w_r_nx = w_ge ? w_sub[XLEN-1:0] : w_sh[XLEN-1:0];
      if (r_f3[1]) w_div_res = r_neg_r ? -w_r_nx : w_r_nx;
      else         w_div_res = r_neg_q ? -w_q_nx : w_q_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_f3      <= '0;
         r_rd      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_out_vld <= 1'b0;
         r_out_res <= '0;
         r_out_rd  <= '0;
      end else if (flush) begin
         r_state   <= S_IDLE;
         r_out_vld <= 1'b0;
         r_cnt     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: if (in_vld) begin
               r_f3    <= in_funct3;
               r_rd    <= in_rd;
               r_rem   <= '0;
               r_cnt   <= '0;
               r_neg_q <= w_sgn && (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]);
               r_neg_r <= w_sgn && in_rs1[XLEN-1];
               if (!in_funct3[2]) begin
                  r_a     <= in_rs1;
                  r_b     <= in_rs2;
                  r_state <= S_MUL;
               end else if (w_dz || w_ovf) begin
                  r_a       <= in_rs1;
                  r_b       <= in_rs2;
                  r_out_res <= w_spec;
                  r_out_rd  <= in_rd;
                  r_out_vld <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_a     <= w_abs_a;
                  r_b     <= w_abs_b;
                  r_state <= S_DIV;
               end
            end
            S_MUL: begin
               r_out_res <= w_mul_res;
               r_out_rd  <= r_rd;
               r_out_vld <= 1'b1;
               r_state   <= S_DONE;
            end
            S_DIV: begin
               r_a   <= w_q_nx;
               r_rem <= w_r_nx;
               if (r_cnt == LAST) begin
                  r_cnt     <= '0;
                  r_out_res <= w_div_res;
                  r_out_rd  <= r_rd;
                  r_out_vld <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DONE: if (out_rdy) begin
               r_out_vld <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign in_rdy     = (r_state == S_IDLE);
   assign out_vld    = r_out_vld;
   assign out_result = r_out_res;
   assign out_rd     = r_out_rd;
endmodule

// File: tb/tb_toy_mdu.sv
// tb_toy_mdu: scoreboard bench for the RV32M multiply/divide unit.
// Directed cases from the feature list plus a reference-model random run.
`timescale 1ns/1ps
module tb_toy_mdu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_rs1 = '0;
   logic [31:0] in_rs2 = '0;
   logic [4:0]  in_rd = '0;
   logic        out_vld;
   logic        out_rdy = 1'b1;
   logic [31:0] out_result;
   logic [4:0]  out_rd;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
   } exp_t;
   exp_t sq[$];

   toy_mdu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .in_funct3  (in_funct3),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_rd      (in_rd),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_result (out_result),
      .out_rd     (out_rd)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_res(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p = '0;
      case (f3)
         3'd0: p = sa * sb;
         3'd1: p = sa * sb;
         3'd2: p = sa * ub;
         3'd3: p = ua * ub;
         default: p = '0;
      endcase
      if (f3 == 3'd0) return p[31:0];
      if (!f3[2]) return p[63:32];
      if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return f3[1] ? 32'd0 : a;
      case (f3)
         3'd4: return $signed(a) / $signed(b);
         3'd5: return a / b;
         3'd6: return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      if (!f3[2]) return 2;
      if (b == 32'd0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic send(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] res, input int lat,
                       input bit push);
      exp_t e;
      @(negedge clk);
      in_vld = 1'b1;
      in_funct3 = f3;
      in_rs1 = a;
      in_rs2 = b;
      in_rd = rd;
      e.res = res;
      e.rd = rd;
      e.lat = lat;
      if (push) sq.push_back(e);
      @(posedge clk); #1;
      in_vld = 1'b0;
      in_funct3 = 3'($urandom);
      in_rs1 = $urandom;
      in_rs2 = $urandom;
      in_rd = 5'($urandom);
   endtask

   task automatic wait_out(output int n, output bit to, output bit rdy);
      n = 1;
      rdy = in_rdy;
      while (!out_vld && n < 60) begin
         @(posedge clk); #1;
         n++;
         rdy = rdy | in_rdy;
      end
      to = !out_vld;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (in_rdy !== 1'b1) $display("FAIL rst_in_rdy got %b want 1", in_rdy);
      else n_pass++;
      n_total++;
      if (out_vld !== 1'b0) $display("FAIL rst_out_vld got %b want 0", out_vld);
      else n_pass++;
      n_total++;
      if (out_result !== 32'd0 || out_rd !== 5'd0)
         $display("FAIL rst_out got %h/%0d want 0/0", out_result, out_rd);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      logic [2:0]  f3 [4];
      logic [31:0] a [4];
      logic [31:0] b [4];
      logic [31:0] r [4];
      int n;
      bit to, rdy;
      exp_t e;
      f3 = '{3'd0, 3'd1, 3'd3, 3'd2};
      a = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      b = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      r = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      for (int i = 0; i < 4; i++) begin
         send(f3[i], a[i], b[i], 5'(i + 5), r[i], 2, 1'b1);
         wait_out(n, to, rdy);
         e = sq.pop_front();
         n_total++;
         if (to || out_result !== e.res || out_rd !== e.rd)
            $display("FAIL mul%0d got %h rd %0d want %h rd %0d",
                     i, out_result, out_rd, e.res, e.rd);
         else n_pass++;
         n_total++;
         if (n !== e.lat) $display("FAIL mul%0d_lat got %0d want %0d", i, n, e.lat);
         else n_pass++;
         @(posedge clk); #1;
         n_total++;
         if (out_vld !== 1'b0 || in_rdy !== 1'b1)
            $display("FAIL mul%0d_pulse got vld %b rdy %b want 0 1", i, out_vld, in_rdy);
         else n_pass++;
      end
   endtask

   task automatic test_div();
      logic [2:0]  f3 [4];
      logic [31:0] a [4];
      logic [31:0] b [4];
      logic [31:0] r [4];
      int n;
      bit to, rdy;
      exp_t e;
      f3 = '{3'd4, 3'd6, 3'd5, 3'd7};
      a = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      b = '{32'd2, 32'd2, 32'd7, 32'd7};
      r = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      for (int i = 0; i < 4; i++) begin
         send(f3[i], a[i], b[i], 5'(i + 20), r[i], 33, 1'b1);
         wait_out(n, to, rdy);
         e = sq.pop_front();
         n_total++;
         if (to || out_result !== e.res || out_rd !== e.rd)
            $display("FAIL div%0d got %h rd %0d want %h rd %0d",
                     i, out_result, out_rd, e.res, e.rd);
         else n_pass++;
         n_total++;
         if (n !== e.lat) $display("FAIL div%0d_lat got %0d want %0d", i, n, e.lat);
         else n_pass++;
         n_total++;
         if (rdy !== 1'b0) $display("FAIL div%0d_busy in_rdy seen %b want 0", i, rdy);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_special();
      logic [2:0]  f3 [4];
      logic [31:0] a [4];
      logic [31:0] b [4];
      logic [31:0] r [4];
      int n;
      bit to, rdy;
      exp_t e;
      f3 = '{3'd5, 3'd7, 3'd4, 3'd6};
      a = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      b = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      r = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      for (int i = 0; i < 4; i++) begin
         send(f3[i], a[i], b[i], 5'(i + 10), r[i], 1, 1'b1);
         wait_out(n, to, rdy);
         e = sq.pop_front();
         n_total++;
         if (to || out_result !== e.res || out_rd !== e.rd)
            $display("FAIL spec%0d got %h rd %0d want %h rd %0d",
                     i, out_result, out_rd, e.res, e.rd);
         else n_pass++;
         n_total++;
         if (n !== e.lat) $display("FAIL spec%0d_lat got %0d want %0d", i, n, e.lat);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int n;
      bit to, rdy;
      exp_t e;
      out_rdy = 1'b0;
      send(3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 2, 1'b1);
      wait_out(n, to, rdy);
      e = sq.pop_front();
      in_vld = 1'b1;
      in_funct3 = 3'd0;
      in_rs1 = 32'd100;
      in_rs2 = 32'd100;
      in_rd = 5'd1;
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if (to || out_vld !== 1'b1 || out_result !== e.res ||
             out_rd !== e.rd || in_rdy !== 1'b0)
            $display("FAIL bp_hold%0d got vld %b res %h rdy %b want 1 %h 0",
                     i, out_vld, out_result, in_rdy, e.res);
         else n_pass++;
         @(posedge clk); #1;
      end
      in_vld = 1'b0;
      out_rdy = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1)
         $display("FAIL bp_release got vld %b rdy %b want 0 1", out_vld, in_rdy);
      else n_pass++;
      send(3'd0, 32'd5, 32'd6, 5'd3, 32'd30, 2, 1'b1);
      wait_out(n, to, rdy);
      e = sq.pop_front();
      n_total++;
      if (to || out_result !== e.res || out_rd !== e.rd || n !== e.lat)
         $display("FAIL bp_next got %h rd %0d lat %0d want %h rd %0d lat %0d",
                  out_result, out_rd, n, e.res, e.rd, e.lat);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      int n;
      bit to, rdy, seen;
      exp_t e;
      send(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'd0, 0, 1'b0);
      repeat (10) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_total++;
      if (in_rdy !== 1'b1 || out_vld !== 1'b0)
         $display("FAIL flush_idle got rdy %b vld %b want 1 0", in_rdy, out_vld);
      else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen = seen | out_vld;
         @(posedge clk); #1;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL flush_kill got out_vld %b want 0", seen);
      else n_pass++;
      send(3'd5, 32'd9, 32'd3, 5'd9, 32'd3, 33, 1'b1);
      wait_out(n, to, rdy);
      e = sq.pop_front();
      n_total++;
      if (to || out_result !== e.res || out_rd !== e.rd || n !== e.lat)
         $display("FAIL flush_next got %h rd %0d lat %0d want %h rd %0d lat %0d",
                  out_result, out_rd, n, e.res, e.rd, e.lat);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_flush_accept();
      bit seen;
      @(negedge clk);
      in_vld = 1'b1;
      flush = 1'b1;
      in_funct3 = 3'd0;
      in_rs1 = 32'd2;
      in_rs2 = 32'd2;
      in_rd = 5'd2;
      @(posedge clk); #1;
      in_vld = 1'b0;
      flush = 1'b0;
      n_total++;
      if (in_rdy !== 1'b1) $display("FAIL flush_acc_rdy got %b want 1", in_rdy);
      else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         seen = seen | out_vld;
         @(posedge clk); #1;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL flush_acc_vld got %b want 0", seen);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      bit seen;
      send(3'd5, 32'd100, 32'd7, 5'd7, 32'd0, 0, 1'b0);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_total++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1 ||
          out_result !== 32'd0 || out_rd !== 5'd0)
         $display("FAIL areset got vld %b rdy %b res %h rd %0d want 0 1 0 0",
                  out_vld, in_rdy, out_result, out_rd);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         seen = seen | out_vld;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL areset_partial got vld %b want 0", seen);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] a, b;
      int n, d;
      bit to, rdy;
      exp_t e;
      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'd0;
         if ($urandom_range(0, 7) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         d = $urandom_range(0, 3);
         out_rdy = (d == 0);
         send(f3, a, b, 5'(i), ref_res(f3, a, b), ref_lat(f3, a, b), 1'b1);
         wait_out(n, to, rdy);
         e = sq.pop_front();
         n_total++;
         if (to || out_result !== e.res || out_rd !== e.rd || n !== e.lat)
            $display("FAIL rnd%0d f3 %0d a %h b %h got %h lat %0d want %h lat %0d",
                     i, f3, a, b, out_result, n, e.res, e.lat);
         else n_pass++;
         repeat (d) begin
            @(posedge clk); #1;
         end
         out_rdy = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_backpressure();
      test_flush();
      test_flush_accept();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout after %0d checks", n_total);
      $fatal(1, "timeout");
   end
endmodule
